// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: state-word width and the serial shifter FSM encoding.
package gpio_pkg;

    localparam int GPIO_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LATCH = 2'd3
    } shift_state_e;

    // Counter width able to hold 0..n-1; a 1-bit counter is kept even for n == 1.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/gpio_shift_out_clk_div_tick.sv
// Phase timer for the serial shifter: one-cycle tick every CLK_DIV cycles,
// restarted whenever the FSM enters a new state.
module clk_div_tick
    import gpio_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] divcnt;

    assign tick = (divcnt == LAST);

    // Count cycles within the current phase; wrap on tick or on a new phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divcnt <= '0;
        end else if (restart || tick) begin
            divcnt <= '0;
        end else begin
            divcnt <= divcnt + ONE;
        end
    end

endmodule

// File: rtl/gpio_shift_out.sv
// Ships the GPIO state word MSB-first into an external 595-style chain and latches it.
// Optional feature macro GPIO_SHIFT_OE_EN adds the active-low ser_oe_n output.
module gpio_shift_out
    import gpio_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int WIDTH   = GPIO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gpio_state,
    output logic             ser_data,
    output logic             ser_clk,
    output logic             ser_latch,
    output logic             busy
`ifdef GPIO_SHIFT_OE_EN
    ,
    output logic             ser_oe_n
`endif
);

    localparam int BW = cnt_width(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    shift_state_e     state;
    shift_state_e     state_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] shipped;
    logic [WIDTH-1:0] shipped_next;
    logic [BW-1:0]    bitcnt;
    logic [BW-1:0]    bitcnt_next;
    logic             refresh;
    logic             refresh_next;
    logic             data_next;
    logic             tick;
    logic             restart;

    // Every phase change is a state change, so restarting on it times each phase.
    assign restart = (state_next != state);

    clk_div_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    // Next-state, shift-register and output-data decode.
    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        shipped_next = shipped;
        bitcnt_next  = bitcnt;
        refresh_next = refresh;
        data_next    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (refresh || (gpio_state != shipped)) begin
                    shreg_next   = gpio_state;
                    shipped_next = gpio_state;
                    refresh_next = 1'b0;
                    bitcnt_next  = '0;
                    state_next   = ST_SETUP;
                end else begin
                    state_next   = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_next = ST_HIGH;
                end else begin
                    state_next = ST_SETUP;
                end
            end
            ST_HIGH: begin
                if (tick) begin
                    shreg_next = {shreg[WIDTH-2:0], 1'b0};
                    if (bitcnt == LAST_BIT) begin
                        state_next = ST_LATCH;
                    end else begin
                        bitcnt_next = bitcnt + BIT_ONE;
                        state_next  = ST_SETUP;
                    end
                end else begin
                    state_next = ST_HIGH;
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_LATCH;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Data is held through SETUP and HIGH so the chain sees margin on both sides.
        if ((state_next == ST_SETUP) || (state_next == ST_HIGH)) begin
            data_next = shreg_next[WIDTH-1];
        end else begin
            data_next = 1'b0;
        end
    end

    // State registers plus outputs registered from the next-state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            shipped   <= '0;
            bitcnt    <= '0;
            refresh   <= 1'b1;
            ser_data  <= 1'b0;
            ser_clk   <= 1'b0;
            ser_latch <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            shreg     <= shreg_next;
            shipped   <= shipped_next;
            bitcnt    <= bitcnt_next;
            refresh   <= refresh_next;
            ser_data  <= data_next;
            ser_clk   <= (state_next == ST_HIGH);
            ser_latch <= (state_next == ST_LATCH);
            busy      <= (state_next != ST_IDLE);
        end
    end

`ifdef GPIO_SHIFT_OE_EN
    // Chip outputs stay disabled until the first complete word has been latched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ser_oe_n <= 1'b1;
        end else if ((state == ST_LATCH) && (state_next == ST_IDLE)) begin
            ser_oe_n <= 1'b0;
        end else begin
            ser_oe_n <= ser_oe_n;
        end
    end
`endif

endmodule

// File: tb/tb_gpio_shift_out.sv
// Self-checking bench for gpio_shift_out: directed table, corner sequences and random traffic.
module tb_gpio_shift_out;
    import gpio_pkg::*;

    localparam int D    = 2;
    localparam int W    = GPIO_WIDTH;
    localparam int FLEN = 2 * W * D + D;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] gpio_state = '0;
    logic         ser_data, ser_clk, ser_latch, busy;
`ifdef GPIO_SHIFT_OE_EN
    logic         ser_oe_n;
`endif

    gpio_shift_out #(.CLK_DIV(D), .WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .gpio_state (gpio_state),
        .ser_data   (ser_data),
        .ser_clk    (ser_clk),
        .ser_latch  (ser_latch),
        .busy       (busy)
`ifdef GPIO_SHIFT_OE_EN
        ,
        .ser_oe_n   (ser_oe_n)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame timeline by arithmetic) ----------------
    logic         m_active  = 1'b0;
    int           m_k       = 0;
    logic [W-1:0] m_word    = '0;
    logic [W-1:0] m_shipped = '0;
    logic         m_refresh = 1'b1;
    logic         m_done    = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active  <= 1'b0;
            m_k       <= 0;
            m_shipped <= '0;
            m_refresh <= 1'b1;
            m_done    <= 1'b0;
        end else if (m_active) begin
            if (m_k == FLEN - 1) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
            end
            m_k <= m_k + 1;
        end else if (m_refresh || (gpio_state != m_shipped)) begin
            m_active  <= 1'b1;
            m_k       <= 0;
            m_word    <= gpio_state;
            m_shipped <= gpio_state;
            m_refresh <= 1'b0;
        end
    end

    // Per-cycle comparison of every output with the model's timeline.
    always @(negedge clk) begin
        check("busy", busy, m_active);
        check("ser_clk", ser_clk, m_active && (m_k < 2 * W * D) && ((m_k % (2 * D)) >= D));
        check("ser_latch", ser_latch, m_active && (m_k >= 2 * W * D));
        if (m_active && (m_k < 2 * W * D)) begin
            check("ser_data", ser_data, m_word[W - 1 - m_k / (2 * D)]);
        end
`ifdef GPIO_SHIFT_OE_EN
        check("ser_oe_n", ser_oe_n, !m_done);
`endif
    end

    // ---------------- frame monitor ----------------
    int           cyc = 0;
    logic         p_busy = 1'b0, p_clk = 1'b0, p_latch = 1'b0;
    logic [W-1:0] acc = '0, last_word = '0;
    int           nb = 0, blen = 0, lat = 0, lw = 0, rise_gap = 0, fall_cyc = 0;
    int           last_nb = 0, last_len = 0, last_lat = 0, last_lw = 0, last_gap = 0;
    int           frames_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy && !p_busy) begin
            acc      <= '0;
            nb       <= 0;
            lat      <= 0;
            lw       <= 0;
            blen     <= 1;
            rise_gap <= cyc - fall_cyc;
        end else if (busy) begin
            blen <= blen + 1;
            if (ser_clk && !p_clk) begin
                acc <= {acc[W-2:0], ser_data};
                nb  <= nb + 1;
            end
            if (ser_latch) lw <= lw + 1;
            if (ser_latch && !p_latch) lat <= lat + 1;
        end
        if (!busy && p_busy) begin
            last_word   <= acc;
            last_nb     <= nb;
            last_len    <= blen;
            last_lat    <= lat;
            last_lw     <= lw;
            last_gap    <= rise_gap;
            fall_cyc    <= cyc;
            frames_done <= frames_done + 1;
        end
        p_busy  <= busy;
        p_clk   <= ser_clk;
        p_latch <= ser_latch;
    end

    // ---------------- helpers ----------------
    task automatic tick_n();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            tick_n();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle wait", ok, 1'b1);
    endtask

    task automatic wait_frames(input int target);
        for (int i = 0; i < 1000; i++) begin
            if (frames_done >= target) break;
            tick_n();
        end
        check("frame wait", frames_done >= target, 1'b1);
    endtask

    task automatic check_frame(input string name, input logic [W-1:0] word);
        check({name, " word"}, last_word, word);
        check({name, " bits"}, last_nb, W);
        check({name, " length"}, last_len, FLEN);
        check({name, " latch pulses"}, last_lat, 1);
        check({name, " latch width"}, last_lw, D);
    endtask

    typedef struct {
        logic [W-1:0] val;
        bit           frame;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int fd0;
        int r;
        vecs[0] = '{32'h8000_0001, 1'b1};
        vecs[1] = '{32'h8000_0001, 1'b0};
        vecs[2] = '{32'hDEAD_BEEF, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{32'h0000_0000, 1'b1};
        vecs[5] = '{32'h0000_0000, 1'b0};

        // Reset state and refresh frame of an all-zero word.
        repeat (3) tick_n();
        check("reset busy", busy, 1'b0);
        check("reset ser_clk", ser_clk, 1'b0);
        check("reset ser_data", ser_data, 1'b0);
        check("reset ser_latch", ser_latch, 1'b0);
`ifdef GPIO_SHIFT_OE_EN
        check("reset ser_oe_n", ser_oe_n, 1'b1);
`endif
        fd0 = frames_done;
        rst = 1'b0;
        wait_frames(fd0 + 1);
        check_frame("refresh", 32'h0);
        repeat (20) tick_n();
        check("after refresh frame count", frames_done, fd0 + 1);
        check("after refresh busy", busy, 1'b0);

        // Table of single updates, including unchanged rewrites.
        for (int i = 0; i < 6; i++) begin
            wait_idle();
            fd0 = frames_done;
            gpio_state = vecs[i].val;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d busy rise", i), busy, vecs[i].frame);
            if (vecs[i].frame) begin
                wait_frames(fd0 + 1);
                check_frame($sformatf("vec%0d", i), vecs[i].val);
            end else begin
                repeat (20) tick_n();
                check($sformatf("vec%0d no frame", i), frames_done, fd0);
            end
        end

        // Coalescing: two writes during a frame yield one follow-up with the last value.
        wait_idle();
        fd0 = frames_done;
        gpio_state = 32'h1234_5678;
        repeat (20) tick_n();
        gpio_state = 32'h0000_00AA;
        repeat (30) tick_n();
        gpio_state = 32'h0000_0055;
        wait_frames(fd0 + 1);
        check_frame("coalesce first", 32'h1234_5678);
        wait_frames(fd0 + 2);
        check_frame("coalesce follow-up", 32'h0000_0055);
        check("coalesce idle gap", last_gap, 1);
        repeat (200) tick_n();
        check("coalesce frame count", frames_done, fd0 + 2);

        // Reset mid-frame at bit 10: abandoned without latch, then refresh.
        wait_idle();
        fd0 = frames_done;
        gpio_state = 32'hA5A5_0F0F;
        for (int i = 0; i < 400; i++) begin
            if (busy && (nb >= 10)) break;
            tick_n();
        end
        check("reached bit 10", nb, 10);
        #1 rst = 1'b1;
        #1;
        check("midreset busy", busy, 1'b0);
        check("midreset ser_clk", ser_clk, 1'b0);
        check("midreset ser_data", ser_data, 1'b0);
        check("midreset ser_latch", ser_latch, 1'b0);
        repeat (3) tick_n();
        check("midreset frame ended", frames_done, fd0 + 1);
        check("midreset no latch", last_lat, 0);
        rst = 1'b0;
        wait_frames(fd0 + 2);
        check_frame("post-reset refresh", 32'hA5A5_0F0F);

        // Random traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 140)) tick_n();
            r = $urandom_range(0, 19);
            if (r < 12) begin
                gpio_state = $urandom;
            end else if (r < 16) begin
                gpio_state = gpio_state;
            end else if (r < 19) begin
                gpio_state[$urandom_range(0, W - 1)] = ~gpio_state[$urandom_range(0, W - 1)];
            end else begin
                #1 rst = 1'b1;
                repeat (2) tick_n();
                rst = 1'b0;
            end
        end
        wait_idle();
        repeat (5) tick_n();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
